ks_data_path_gen: RTL and testbench
===================================

# ks_data_path_gen

Parametrised next-generation K&S processor data path: instruction register, program counter, NUM_REGS-entry register file, extended ALU, flag register and memory address mux. The control unit drives it through the same strobe set as the 16-bit data path, plus a 3-bit operation code. Data width, register count and memory depth are parameters. All state is resettable.

## Interface
- DATA_W, 16, data/instruction width; legal range 16..64
- NUM_REGS, 4, register-file entries; power of two, 2..16; RSEL_W = clog2(NUM_REGS)
- ADDR_W, 5, memory address width; must satisfy 8+RSEL_W+ADDR_W <= DATA_W and 8+3*RSEL_W <= DATA_W
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable  in  1 each  control strobes
- operation  in  3  ALU op select
- decoded_instruction  out  decoded_instruction_type (k_and_s_pkg, includes I_XOR/I_SHL/I_SHR)  current IR decode
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags
- ram_addr  out  ADDR_W  memory address
- data_out  out  DATA_W  store data (= bus_a)
- data_in  in  DATA_W  memory read data

## Operation
- Opcode = IR[DATA_W-1 -: 8]. LOAD 0x81, STORE 0x82, MOVE 0x91, ADD 0xA1, SUB 0xA2, AND 0xA3, OR 0xA4, XOR 0xA5, SHL 0xA6, SHR 0xA7, BRANCH 0x01, BZERO 0x02, BNEG 0x03, BOV 0x05, BNOV 0x06, BNNEG 0x0A, BNZERO 0x0B, HALT 0xFF; anything else I_NOP.
- Fields: mem_addr = IR[ADDR_W-1:0]; LOAD c / STORE a = IR[ADDR_W+RSEL_W-1:ADDR_W]; MOVE c = IR[2R-1:R], a = b = IR[R-1:0]; ALU a = IR[R-1:0], b = IR[2R-1:R], c = IR[3R-1:2R] (R = RSEL_W). Unused selects = 0.
- Register file: bus_a/bus_b are combinational reads. Write on clk edge when write_reg_enable: reg[c] <= c_sel ? alu_out : data_in.
- operation: 000 OR, 001 ADD, 010 SUB (a - b), 011 AND, 100 XOR, 101 SHL a by 1, 110 SHR a by 1 (logical), 111 pass a (MOVE).
- Flags: zero = (alu_out == 0), neg = alu_out[DATA_W-1].
  - ADD: uovf = carry out; sovf = carry into MSB XOR carry out.
  - SUB: uovf = borrow (a < b unsigned); sovf = operand signs differ and result sign != a sign.
  - SHL: uovf = a[DATA_W-1]. SHR: uovf = a[0]. sovf = 0.
  - Logic ops and pass: uovf = sovf = 0.
- ram_addr = addr_sel ? PC : mem_addr (combinational). data_out = bus_a.
- PC: when pc_enable, PC <= branch ? mem_addr : PC + 1, wrapping 2^ADDR_W-1 -> 0.

## Timing
- Reset (async): PC = 0, IR = 0 (decodes I_NOP), all registers = 0, all four flags = 0. Outputs follow combinationally: ram_addr = 0 if addr_sel, data_out = 0.
- IR loads data_in on the clk edge where ir_enable = 1; decode is valid in the same cycle, after the IR updates.
- A register write is visible on bus_a/bus_b the cycle after the write edge. Read-and-write of the same register in one cycle returns the old value.
- Flags update on the edge where flags_reg_enable = 1 and hold otherwise; they are independent of write_reg_enable.
- pc_enable and ir_enable in the same cycle: IR takes data_in, PC advances; both apply.
- rst_n asserted mid-instruction clears all state immediately. The first edge after release behaves as a normal cycle.

## Test plan
- Reset, then ir_enable with data_in=0x8125 (defaults) -> decoded I_LOAD, ram_addr=5 (addr_sel=0). write_reg_enable, c_sel=0, data_in=0x1234 -> R1=0x1234.
- ADD R3=R1+R2 with R1=0x7FFF, R2=0x0001 (IR 0xA139, op 001) -> R3=0x8000, neg=1, sovf=1, uovf=0, zero=0.
- SUB with a=0x0003, b=0x0005 (op 010) -> result 0xFFFE, uovf=1, sovf=0, neg=1. Equal operands -> zero=1.
- SHL on a=0x8001 -> 0x0002, uovf=1. SHR on a=0x0001 -> 0, zero=1, uovf=1.
- PC at 31 with pc_enable, branch=0 -> PC=0 (wrap). Then branch=1 with IR=0x0111 -> PC=17.
- Rebuild with DATA_W=32, NUM_REGS=8, ADDR_W=8: LOAD/ADD encodings using 3-bit register fields hit the correct registers; rst_n pulse mid-run zeroes all 8 registers, PC and flags.

Source files
------------

// File: rtl/ks_data_path_gen.sv
// K&S processor data path, parametrised in data width, register count and memory depth.
// Holds IR, PC, register file, ALU flags and the memory address mux; control comes from outside.

package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SHL, I_SHR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO,
    I_HALT
  } decoded_instruction_type;
endpackage

module ks_data_path_gen
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic [2:0]              operation,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  localparam int RSEL_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] mem_addr;
  logic [RSEL_W-1:0] a_idx, b_idx, c_idx;
  logic [DATA_W-1:0] bus_a, bus_b;
  logic [DATA_W-1:0] alu_out;
  logic              alu_uovf, alu_sovf;
  logic [DATA_W:0]   sum_ext, diff_ext;
  decoded_instruction_type dec;

  // Not every IR bit belongs to a field for every parameter set.
  logic ir_unused;
  assign ir_unused = ^ir;

  assign opcode   = ir[DATA_W-1 -: 8];
  assign mem_addr = ir[ADDR_W-1:0];

  always_comb begin
    dec = I_NOP;
    case (opcode)
      8'h81:   dec = I_LOAD;
      8'h82:   dec = I_STORE;
      8'h91:   dec = I_MOVE;
      8'hA1:   dec = I_ADD;
      8'hA2:   dec = I_SUB;
      8'hA3:   dec = I_AND;
      8'hA4:   dec = I_OR;
      8'hA5:   dec = I_XOR;
      8'hA6:   dec = I_SHL;
      8'hA7:   dec = I_SHR;
      8'h01:   dec = I_BRANCH;
      8'h02:   dec = I_BZERO;
      8'h03:   dec = I_BNEG;
      8'h05:   dec = I_BOV;
      8'h06:   dec = I_BNOV;
      8'h0A:   dec = I_BNNEG;
      8'h0B:   dec = I_BNZERO;
      8'hFF:   dec = I_HALT;
      default: dec = I_NOP;
    endcase
  end

  assign decoded_instruction = dec;

  // Register selects depend on the instruction format; unused selects read/write R0.
  always_comb begin
    a_idx = '0;
    b_idx = '0;
    c_idx = '0;
    case (dec)
      I_LOAD:  c_idx = ir[ADDR_W +: RSEL_W];
      I_STORE: a_idx = ir[ADDR_W +: RSEL_W];
      I_MOVE: begin
        c_idx = ir[RSEL_W +: RSEL_W];
        a_idx = ir[0 +: RSEL_W];
        b_idx = ir[0 +: RSEL_W];
      end
      I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SHL, I_SHR: begin
        a_idx = ir[0 +: RSEL_W];
        b_idx = ir[RSEL_W +: RSEL_W];
        c_idx = ir[2*RSEL_W +: RSEL_W];
      end
      default: ;
    endcase
  end

  assign bus_a    = regs[a_idx];
  assign bus_b    = regs[b_idx];
  assign data_out = bus_a;
  assign ram_addr = addr_sel ? pc : mem_addr;

  assign sum_ext  = {1'b0, bus_a} + {1'b0, bus_b};
  assign diff_ext = {1'b0, bus_a} - {1'b0, bus_b};

  always_comb begin
    alu_out  = bus_a;
    alu_uovf = 1'b0;
    alu_sovf = 1'b0;
    case (operation)
      3'b000: alu_out = bus_a | bus_b;
      3'b001: begin
        alu_out  = sum_ext[DATA_W-1:0];
        alu_uovf = sum_ext[DATA_W];
        // carry into the MSB recovered from the sum bit, compared with carry out
        alu_sovf = (sum_ext[DATA_W-1] ^ bus_a[DATA_W-1] ^ bus_b[DATA_W-1]) ^ sum_ext[DATA_W];
      end
      3'b010: begin
        alu_out  = diff_ext[DATA_W-1:0];
        alu_uovf = diff_ext[DATA_W];
        alu_sovf = (bus_a[DATA_W-1] != bus_b[DATA_W-1]) &&
                   (diff_ext[DATA_W-1] != bus_a[DATA_W-1]);
      end
      3'b011: alu_out = bus_a & bus_b;
      3'b100: alu_out = bus_a ^ bus_b;
      3'b101: begin
        alu_out  = {bus_a[DATA_W-2:0], 1'b0};
        alu_uovf = bus_a[DATA_W-1];
      end
      3'b110: begin
        alu_out  = {1'b0, bus_a[DATA_W-1:1]};
        alu_uovf = bus_a[0];
      end
      default: alu_out = bus_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
      pc <= '0;
    end else begin
      if (ir_enable) ir <= data_in;
      if (pc_enable) pc <= branch ? mem_addr : pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_reg_enable) begin
      regs[c_idx] <= c_sel ? alu_out : data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_op           <= (alu_out == '0);
      neg_op            <= alu_out[DATA_W-1];
      unsigned_overflow <= alu_uovf;
      signed_overflow   <= alu_sovf;
    end
  end

endmodule

// File: tb/tb_ks_data_path_gen.sv
// Directed bench for ks_data_path_gen: a default 16-bit instance and a 32-bit/8-register instance.
// Registers are observed through data_out by loading a STORE instruction that selects them.

module tb_ks_data_path_gen;
  import k_and_s_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // 16-bit instance
  logic branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable;
  logic [2:0]  operation;
  logic [15:0] data_in, data_out;
  logic [4:0]  ram_addr;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  decoded_instruction_type dec;
  logic [3:0] flags;
  assign flags = {zero_op, neg_op, unsigned_overflow, signed_overflow};

  ks_data_path_gen dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .operation(operation), .decoded_instruction(dec),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in)
  );

  // 32-bit, 8-register instance
  logic w_branch, w_pc_enable, w_ir_enable, w_addr_sel, w_c_sel, w_write_reg_enable, w_flags_reg_enable;
  logic [2:0]  w_operation;
  logic [31:0] w_data_in, w_data_out;
  logic [7:0]  w_ram_addr;
  logic w_zero, w_neg, w_uovf, w_sovf;
  decoded_instruction_type w_dec;
  logic [3:0] w_flags;
  assign w_flags = {w_zero, w_neg, w_uovf, w_sovf};

  ks_data_path_gen #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .branch(w_branch), .pc_enable(w_pc_enable), .ir_enable(w_ir_enable),
    .addr_sel(w_addr_sel), .c_sel(w_c_sel), .write_reg_enable(w_write_reg_enable),
    .flags_reg_enable(w_flags_reg_enable), .operation(w_operation), .decoded_instruction(w_dec),
    .zero_op(w_zero), .neg_op(w_neg), .unsigned_overflow(w_uovf),
    .signed_overflow(w_sovf), .ram_addr(w_ram_addr), .data_out(w_data_out), .data_in(w_data_in)
  );

  logic [31:0] exp_q[$];

  logic [7:0] op_tab [21] = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                              8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'hFF,
                              8'h00, 8'h04, 8'hA8};
  decoded_instruction_type dec_tab [21] = '{I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
                              I_XOR, I_SHL, I_SHR, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV,
                              I_BNNEG, I_BNZERO, I_HALT, I_NOP, I_NOP, I_NOP};

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    write_reg_enable = 0; flags_reg_enable = 0; operation = 3'b111; data_in = '0;
    w_branch = 0; w_pc_enable = 0; w_ir_enable = 0; w_addr_sel = 0; w_c_sel = 0;
    w_write_reg_enable = 0; w_flags_reg_enable = 0; w_operation = 3'b111; w_data_in = '0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    data_in = v; ir_enable = 1; tick(); ir_enable = 0;
  endtask

  task automatic write_reg(input int n, input logic [15:0] v);
    load_ir(16'h8100 | 16'(n << 5));
    data_in = v; c_sel = 0; write_reg_enable = 1; tick(); write_reg_enable = 0;
  endtask

  task automatic read_reg(input int n, output logic [15:0] v);
    load_ir(16'h8200 | 16'(n << 5));
    v = data_out;
  endtask

  task automatic alu(input logic [15:0] instr, input logic [2:0] op);
    load_ir(instr);
    operation = op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1;
    tick();
    write_reg_enable = 0; flags_reg_enable = 0; c_sel = 0;
  endtask

  task automatic w_load_ir(input logic [31:0] v);
    w_data_in = v; w_ir_enable = 1; tick(); w_ir_enable = 0;
  endtask

  task automatic w_write_reg(input int n, input logic [31:0] v);
    w_load_ir(32'h8100_0000 | 32'(n << 8));
    w_data_in = v; w_c_sel = 0; w_write_reg_enable = 1; tick(); w_write_reg_enable = 0;
  endtask

  task automatic w_read_reg(input int n, output logic [31:0] v);
    w_load_ir(32'h8200_0000 | 32'(n << 8));
    v = w_data_out;
  endtask

  task automatic w_alu(input logic [31:0] instr, input logic [2:0] op);
    w_load_ir(instr);
    w_operation = op; w_c_sel = 1; w_write_reg_enable = 1; w_flags_reg_enable = 1;
    tick();
    w_write_reg_enable = 0; w_flags_reg_enable = 0; w_c_sel = 0;
  endtask

  // scenarios
  task automatic test_reset();
    idle_all();
    rst_n = 0;
    addr_sel = 1;
    #1;
    checks++; if (ram_addr !== 5'd0) $display("FAIL reset_pc got=%0h exp=0", ram_addr); else passed++;
    checks++; if (data_out !== 16'h0) $display("FAIL reset_data_out got=%0h exp=0", data_out); else passed++;
    checks++; if (flags !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags); else passed++;
    checks++; if (dec !== I_NOP) $display("FAIL reset_decode got=%s exp=I_NOP", dec.name()); else passed++;
    tick(); tick();
    rst_n = 1;
    addr_sel = 0;
    tick();
  endtask

  task automatic test_decode();
    for (int i = 0; i < 21; i++) begin
      load_ir({op_tab[i], 8'h00});
      checks++;
      if (dec !== dec_tab[i])
        $display("FAIL decode_%02h got=%s exp=%s", op_tab[i], dec.name(), dec_tab[i].name());
      else passed++;
    end
  endtask

  task automatic test_load();
    logic [15:0] v;
    load_ir(16'h8125);
    addr_sel = 0;
    checks++; if (dec !== I_LOAD) $display("FAIL load_decode got=%s exp=I_LOAD", dec.name()); else passed++;
    checks++; if (ram_addr !== 5'd5) $display("FAIL load_ram_addr got=%0h exp=5", ram_addr); else passed++;
    data_in = 16'h1234; c_sel = 0; write_reg_enable = 1; tick(); write_reg_enable = 0;
    read_reg(1, v);
    checks++; if (v !== 16'h1234) $display("FAIL load_r1 got=%h exp=1234", v); else passed++;
  endtask

  task automatic test_same_reg();
    load_ir(16'h8100);
    data_in = 16'hBEEF; c_sel = 0; write_reg_enable = 1;
    #1;
    checks++; if (data_out !== 16'h0000) $display("FAIL rw_old got=%h exp=0000", data_out); else passed++;
    tick();
    write_reg_enable = 0;
    checks++; if (data_out !== 16'hBEEF) $display("FAIL rw_new got=%h exp=beef", data_out); else passed++;
  endtask

  task automatic test_add();
    logic [15:0] v;
    write_reg(1, 16'h7FFF); write_reg(2, 16'h0001);
    alu(16'hA139, 3'b001);
    checks++; if (flags !== 4'b0101) $display("FAIL add_sovf_flags got=%b exp=0101", flags); else passed++;
    read_reg(3, v);
    checks++; if (v !== 16'h8000) $display("FAIL add_sovf_r3 got=%h exp=8000", v); else passed++;
    write_reg(1, 16'hFFFF);
    alu(16'hA139, 3'b001);
    checks++; if (flags !== 4'b1010) $display("FAIL add_carry_flags got=%b exp=1010", flags); else passed++;
    read_reg(3, v);
    checks++; if (v !== 16'h0000) $display("FAIL add_carry_r3 got=%h exp=0000", v); else passed++;
  endtask

  task automatic test_flags_hold();
    logic [15:0] v;
    write_reg(1, 16'h8000);
    load_ir(16'hA139);
    operation = 3'b001; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 0;
    tick();
    write_reg_enable = 0;
    checks++; if (flags !== 4'b1010) $display("FAIL flags_hold got=%b exp=1010", flags); else passed++;
    operation = 3'b011; flags_reg_enable = 1;
    tick();
    flags_reg_enable = 0; c_sel = 0;
    checks++; if (flags !== 4'b1000) $display("FAIL flags_only got=%b exp=1000", flags); else passed++;
    read_reg(3, v);
    checks++; if (v !== 16'h8001) $display("FAIL flags_only_r3 got=%h exp=8001", v); else passed++;
  endtask

  task automatic test_sub();
    logic [15:0] v;
    write_reg(1, 16'h0003); write_reg(2, 16'h0005);
    alu(16'hA239, 3'b010);
    checks++; if (flags !== 4'b0110) $display("FAIL sub_borrow_flags got=%b exp=0110", flags); else passed++;
    read_reg(3, v);
    checks++; if (v !== 16'hFFFE) $display("FAIL sub_borrow_r3 got=%h exp=fffe", v); else passed++;
    write_reg(1, 16'h0005);
    alu(16'hA239, 3'b010);
    checks++; if (flags !== 4'b1000) $display("FAIL sub_equal_flags got=%b exp=1000", flags); else passed++;
    write_reg(1, 16'h8000); write_reg(2, 16'h0001);
    alu(16'hA239, 3'b010);
    checks++; if (flags !== 4'b0001) $display("FAIL sub_sovf_flags got=%b exp=0001", flags); else passed++;
    read_reg(3, v);
    checks++; if (v !== 16'h7FFF) $display("FAIL sub_sovf_r3 got=%h exp=7fff", v); else passed++;
  endtask

  task automatic test_shift();
    logic [15:0] v;
    write_reg(1, 16'h8001);
    alu(16'hA639, 3'b101);
    checks++; if (flags !== 4'b0010) $display("FAIL shl_flags got=%b exp=0010", flags); else passed++;
    read_reg(3, v);
    checks++; if (v !== 16'h0002) $display("FAIL shl_r3 got=%h exp=0002", v); else passed++;
    write_reg(1, 16'h0001);
    alu(16'hA739, 3'b110);
    checks++; if (flags !== 4'b1010) $display("FAIL shr_flags got=%b exp=1010", flags); else passed++;
    read_reg(3, v);
    checks++; if (v !== 16'h0000) $display("FAIL shr_r3 got=%h exp=0000", v); else passed++;
  endtask

  task automatic test_logic_move();
    logic [15:0] v;
    write_reg(1, 16'hF0F0); write_reg(2, 16'hFF00);
    alu(16'hA439, 3'b000);
    read_reg(3, v);
    checks++; if (v !== 16'hFFF0) $display("FAIL or_r3 got=%h exp=fff0", v); else passed++;
    checks++; if (flags !== 4'b0100) $display("FAIL or_flags got=%b exp=0100", flags); else passed++;
    alu(16'hA339, 3'b011);
    read_reg(3, v);
    checks++; if (v !== 16'hF000) $display("FAIL and_r3 got=%h exp=f000", v); else passed++;
    alu(16'hA539, 3'b100);
    read_reg(3, v);
    checks++; if (v !== 16'h0FF0) $display("FAIL xor_r3 got=%h exp=0ff0", v); else passed++;
    checks++; if (flags !== 4'b0000) $display("FAIL xor_flags got=%b exp=0000", flags); else passed++;
    alu(16'h9109, 3'b111);
    read_reg(2, v);
    checks++; if (v !== 16'hF0F0) $display("FAIL move_r2 got=%h exp=f0f0", v); else passed++;
  endtask

  task automatic test_pc();
    addr_sel = 1;
    pc_enable = 1;
    for (int i = 0; i < 31; i++) tick();
    pc_enable = 0;
    checks++; if (ram_addr !== 5'd31) $display("FAIL pc_count got=%0d exp=31", ram_addr); else passed++;
    pc_enable = 1; tick(); pc_enable = 0;
    checks++; if (ram_addr !== 5'd0) $display("FAIL pc_wrap got=%0d exp=0", ram_addr); else passed++;
    load_ir(16'h0111);
    checks++; if (dec !== I_BRANCH) $display("FAIL branch_decode got=%s exp=I_BRANCH", dec.name()); else passed++;
    branch = 1; pc_enable = 1; tick(); branch = 0; pc_enable = 0;
    checks++; if (ram_addr !== 5'd17) $display("FAIL pc_branch got=%0d exp=17", ram_addr); else passed++;
  endtask

  task automatic test_back_to_back();
    data_in = 16'h8103; ir_enable = 1; pc_enable = 1; addr_sel = 1;
    tick();
    ir_enable = 0; pc_enable = 0;
    checks++; if (ram_addr !== 5'd18) $display("FAIL b2b_pc got=%0d exp=18", ram_addr); else passed++;
    checks++; if (dec !== I_LOAD) $display("FAIL b2b_decode got=%s exp=I_LOAD", dec.name()); else passed++;
    addr_sel = 0;
    #1;
    checks++; if (ram_addr !== 5'd3) $display("FAIL b2b_mem_addr got=%0d exp=3", ram_addr); else passed++;
  endtask

  task automatic test_wide();
    logic [31:0] v, e;
    for (int n = 0; n < 8; n++) begin
      w_write_reg(n, 32'h1111_1111 * n);
      exp_q.push_back(32'h1111_1111 * n);
    end
    for (int n = 0; n < 8; n++) begin
      w_read_reg(n, v);
      e = exp_q.pop_front();
      checks++; if (v !== e) $display("FAIL wide_r%0d got=%h exp=%h", n, v, e); else passed++;
    end
    w_alu(32'hA100_01F5, 3'b001);
    checks++; if (w_flags !== 4'b0101) $display("FAIL wide_add_flags got=%b exp=0101", w_flags); else passed++;
    w_read_reg(7, v);
    checks++; if (v !== 32'hBBBB_BBBB) $display("FAIL wide_add_r7 got=%h exp=bbbbbbbb", v); else passed++;
    w_alu(32'hA200_001C, 3'b010);
    w_read_reg(0, v);
    checks++; if (v !== 32'h1111_1111) $display("FAIL wide_sub_r0 got=%h exp=11111111", v); else passed++;
    w_load_ir(32'h8100_00C3);
    w_addr_sel = 0;
    #1;
    checks++; if (w_ram_addr !== 8'hC3) $display("FAIL wide_ram_addr got=%h exp=c3", w_ram_addr); else passed++;
    checks++; if (w_dec !== I_LOAD) $display("FAIL wide_decode got=%s exp=I_LOAD", w_dec.name()); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    w_alu(32'hA100_01F5, 3'b001);
    w_addr_sel = 1; w_pc_enable = 1;
    tick(); tick(); tick();
    w_pc_enable = 0;
    checks++; if (w_ram_addr !== 8'd3) $display("FAIL wide_pc_pre got=%0d exp=3", w_ram_addr); else passed++;
    addr_sel = 1;
    #2;
    rst_n = 0;
    #1;
    checks++; if (w_ram_addr !== 8'd0) $display("FAIL mid_reset_pc got=%0d exp=0", w_ram_addr); else passed++;
    checks++; if (w_flags !== 4'b0000) $display("FAIL mid_reset_flags got=%b exp=0000", w_flags); else passed++;
    checks++; if (w_dec !== I_NOP) $display("FAIL mid_reset_decode got=%s exp=I_NOP", w_dec.name()); else passed++;
    checks++; if (w_data_out !== 32'h0) $display("FAIL mid_reset_data_out got=%h exp=0", w_data_out); else passed++;
    checks++; if (ram_addr !== 5'd0) $display("FAIL mid_reset_pc16 got=%0d exp=0", ram_addr); else passed++;
    tick();
    rst_n = 1;
    for (int n = 0; n < 8; n++) begin
      w_read_reg(n, v);
      checks++; if (v !== 32'h0) $display("FAIL mid_reset_r%0d got=%h exp=0", n, v); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load();
    test_same_reg();
    test_add();
    test_flags_hold();
    test_sub();
    test_shift();
    test_logic_move();
    test_pc();
    test_back_to_back();
    test_wide();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
